stage_sequencer: RTL and testbench

Central control FSM for the multi-cycle core. Launches each instruction by pulsing the fetch-stage kick, tracks the IF->ID->EX->MEM->WB kick_up chain to completion, counts retired instructions, and handles run/step/halt control. A per-stage watchdog catches stalled stages, and a protocol checker catches out-of-order kicks.

---
 rtl/seq_pkg.sv | 45 ++++
 rtl/seq_watchdog.sv | 33 +++
 rtl/stage_sequencer.sv | 151 +++++++++++++++
 tb/tb_stage_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the stage sequencer: state encoding, error codes and
// helpers mapping each stage-wait state to its expected kick and successor.
package seq_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LAUNCH = 4'd1,
      S_IF   = 4'd2,
      S_ID   = 4'd3,
      S_EX   = 4'd4,
      S_MEM  = 4'd5,
      S_WB   = 4'd6,
      HALTED = 4'd7,
      ERROR  = 4'd8
   } seq_state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_ORDER   = 2'd2;

   localparam int DEFAULT_TIMEOUT_CYCLES = 15;

   // Kick vectors are ordered {WB, MEM, EX, ID, IF}; zero means "not a stage-wait state".
   function automatic logic [4:0] expected_kick(input seq_state_t s);
      case (s)
         S_IF:    return 5'b00001;
         S_ID:    return 5'b00010;
         S_EX:    return 5'b00100;
         S_MEM:   return 5'b01000;
         S_WB:    return 5'b10000;
         default: return 5'b00000;
      endcase
   endfunction

   function automatic seq_state_t next_stage(input seq_state_t s);
      case (s)
         S_IF:    return S_ID;
         S_ID:    return S_EX;
         S_EX:    return S_MEM;
         S_MEM:   return S_WB;
         default: return s;
      endcase
   endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage watchdog: counts cycles spent in one stage-wait state and flags
// the cycle in which the LIMIT-th consecutive cycle is being spent there.
module seq_watchdog #(
   parameter  int LIMIT = 15,
   localparam int W     = $clog2(LIMIT + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         limit_hit
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != W'(LIMIT))) begin
         count <= count + W'(1);
      end
   end

   // count is 0 in the first cycle of a state, so LIMIT-1 marks the LIMIT-th cycle.
   assign limit_hit = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Central control FSM for the multi-cycle core: launches instructions, follows
// the IF->ID->EX->MEM->WB kick chain, counts retirements, handles run/step/halt.
module stage_sequencer
   import seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int RETIRE_W       = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                step,
   input  logic                halt_req,
   input  logic                resume,
   input  logic                clear_err,
   input  logic                IF_kick_up,
   input  logic                ID_kick_up,
   input  logic                EX_kick_up,
   input  logic                MEM_kick_up,
   input  logic                WB_kick_up,
   output logic                start_kick,
   output logic [3:0]          state,
   output logic                busy,
   output logic                halted,
   output logic                err,
   output logic [1:0]          err_code,
   output logic [RETIRE_W-1:0] retire_count
);

   // All control inputs and kicks are single-cycle pulses sampled on the rising
   // clock edge; there is no back-pressure, so a pulse is either consumed or ignored.
   seq_state_t          cur, nxt;
   logic                halt_pending, halt_pending_nxt;
   logic                step_mode, step_mode_nxt;
   logic [1:0]          err_code_q, err_code_nxt;
   logic [RETIRE_W-1:0] retire_q;
   logic                retire_inc;
   logic                start_kick_q;

   logic [4:0] kicks;
   logic [4:0] exp_kick;
   logic       in_stage;
   logic       kick_hit;
   logic       order_err;
   logic       limit_hit;
   logic       timeout;

   assign kicks     = {WB_kick_up, MEM_kick_up, EX_kick_up, ID_kick_up, IF_kick_up};
   assign exp_kick  = expected_kick(cur);
   assign in_stage  = |exp_kick;
   assign kick_hit  = |(kicks & exp_kick);
   assign order_err = in_stage && |(kicks & ~exp_kick);
   assign timeout   = in_stage && limit_hit && !kick_hit;

   seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
      .clk        (clk),
      .reset      (reset),
      .clear      (nxt != cur),
      .enable     (in_stage),
      .load       (1'b0),
      .load_value ('0),
      .limit_hit  (limit_hit)
   );

   always_comb begin
      nxt              = cur;
      step_mode_nxt    = step_mode;
      err_code_nxt     = err_code_q;
      retire_inc       = 1'b0;
      halt_pending_nxt = halt_pending;
      if (halt_req && (cur != HALTED) && (cur != ERROR)) begin
         halt_pending_nxt = 1'b1;
      end

      case (cur)
         IDLE: begin
            if (halt_req || halt_pending) begin
               nxt = HALTED;
            end else if (step) begin
               nxt           = LAUNCH;
               step_mode_nxt = 1'b1;
            end else if (run) begin
               nxt           = LAUNCH;
               step_mode_nxt = 1'b0;
            end
         end
         LAUNCH: nxt = S_IF;
         S_IF, S_ID, S_EX, S_MEM, S_WB: begin
            // Protocol error outranks a valid advance, which outranks timeout.
            if (order_err) begin
               nxt          = ERROR;
               err_code_nxt = ERR_ORDER;
            end else if (kick_hit) begin
               if (cur == S_WB) begin
                  retire_inc = 1'b1;
                  if (halt_pending || halt_req) nxt = HALTED;
                  else if (step_mode)           nxt = IDLE;
                  else if (run)                 nxt = LAUNCH;
                  else                          nxt = IDLE;
               end else begin
                  nxt = next_stage(cur);
               end
            end else if (timeout) begin
               nxt          = ERROR;
               err_code_nxt = ERR_TIMEOUT;
            end
         end
         HALTED: if (resume) nxt = IDLE;
         ERROR: begin
            if (clear_err) begin
               nxt          = IDLE;
               err_code_nxt = ERR_NONE;
            end
         end
         default: nxt = IDLE;
      endcase

      // A halt is consumed on entering HALTED; an abandoned instruction drops it.
      if ((nxt == HALTED) || (nxt == ERROR)) begin
         halt_pending_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur          <= IDLE;
         halt_pending <= 1'b0;
         step_mode    <= 1'b0;
         err_code_q   <= ERR_NONE;
         retire_q     <= '0;
         start_kick_q <= 1'b0;
      end else begin
         cur          <= nxt;
         halt_pending <= halt_pending_nxt;
         step_mode    <= step_mode_nxt;
         err_code_q   <= err_code_nxt;
         if (retire_inc) retire_q <= retire_q + RETIRE_W'(1);
         // Registered while in LAUNCH, so the pulse lands in the first S_IF cycle.
         start_kick_q <= (cur == LAUNCH);
      end
   end

   assign start_kick   = start_kick_q;
   assign state        = cur;
   assign busy         = (cur == LAUNCH) || in_stage;
   assign halted       = (cur == HALTED);
   assign err          = (cur == ERROR);
   assign err_code     = err_code_q;
   assign retire_count = retire_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: run/step/halt control, kick chain,
// watchdog timeout, kick-order errors, retire counter wrap and async reset.
module tb_stage_sequencer;

   localparam logic [3:0] ST_IDLE = 4'd0, ST_LAUNCH = 4'd1, ST_IF = 4'd2, ST_ID = 4'd3,
                          ST_EX = 4'd4, ST_MEM = 4'd5, ST_WB = 4'd6, ST_HALTED = 4'd7,
                          ST_ERROR = 4'd8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0, step = 1'b0, halt_req = 1'b0, resume = 1'b0, clear_err = 1'b0;
   logic [4:0] kick = 5'b0;
   logic       start_kick, busy, halted, err;
   logic [3:0] state;
   logic [1:0] err_code;
   logic [3:0] retire_count;

   int         checks = 0;
   int         fails = 0;
   int         cyc = 0;
   int         start_cnt = 0;
   int         wb_cyc = 0;
   logic [3:0] exp_retire = 4'd0;
   logic [3:0] exp_q[$];
   logic [3:0] obs_q[$];

   stage_sequencer #(.TIMEOUT_CYCLES(15), .RETIRE_W(4)) dut (
      .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
      .resume(resume), .clear_err(clear_err),
      .IF_kick_up(kick[0]), .ID_kick_up(kick[1]), .EX_kick_up(kick[2]),
      .MEM_kick_up(kick[3]), .WB_kick_up(kick[4]),
      .start_kick(start_kick), .state(state), .busy(busy), .halted(halted),
      .err(err), .err_code(err_code), .retire_count(retire_count)
   );

   // clock, cycle counter and start_kick pulse counter
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (start_kick) start_cnt <= start_cnt + 1;
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      reset = 1'b1; run = 0; step = 0; halt_req = 0; resume = 0; clear_err = 0; kick = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_retire = 4'd0;
      @(negedge clk);
   endtask

   task automatic wait_state(input logic [3:0] target, input int budget);
      int n = 0;
      while (state !== target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (state !== target) begin
         checks++; fails++;
         $display("FAIL wait_state: got %0d want %0d after %0d cycles", state, target, budget);
      end
   endtask

   // Walks stage indices first..last (0=IF .. 4=WB), kicking each after 'delay' cycles.
   task automatic run_stages(input int first, input int last, input int delay, input int halt_stage);
      for (int s = first; s <= last; s++) begin
         obs_q.push_back(state);
         if (s == halt_stage) halt_req = 1'b1;
         for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            halt_req = 1'b0;
         end
         kick[s] = 1'b1;
         if (s == 4) wb_cyc = cyc;
         @(negedge clk);
         kick = 5'b0;
         halt_req = 1'b0;
         if (s == 4) exp_retire = exp_retire + 4'd1;
      end
   endtask

   task automatic pulse_step();
      step = 1'b1; @(negedge clk); step = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (state !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
      checks++; if ({start_kick, busy, halted, err} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {start_kick, busy, halted, err}); end
      checks++; if (err_code !== 2'd0) begin fails++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
      checks++; if (retire_count !== 4'd0) begin fails++; $display("FAIL reset_retire: got %0d want 0", retire_count); end
      apply_reset();
      checks++; if (state !== ST_IDLE) begin fails++; $display("FAIL reset_release_state: got %0d want %0d", state, ST_IDLE); end
   endtask

   task automatic test_step();
      int base = start_cnt;
      pulse_step();
      checks++; if (state !== ST_LAUNCH || start_kick !== 1'b0) begin fails++; $display("FAIL step_launch: got state %0d kick %b want 1/0", state, start_kick); end
      @(negedge clk);
      checks++; if (state !== ST_IF || start_kick !== 1'b1) begin fails++; $display("FAIL step_start_kick: got state %0d kick %b want 2/1", state, start_kick); end
      exp_q = '{ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB};
      obs_q.delete();
      run_stages(0, 4, 3, -1);
      checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL step_walk_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [3:0] e = exp_q.pop_front();
         logic [3:0] o = obs_q.pop_front();
         checks++; if (o !== e) begin fails++; $display("FAIL step_walk: got %0d want %0d", o, e); end
      end
      checks++; if (state !== ST_IDLE || busy !== 1'b0) begin fails++; $display("FAIL step_end: got state %0d busy %b want 0/0", state, busy); end
      checks++; if (retire_count !== 4'd1) begin fails++; $display("FAIL step_retire: got %0d want 1", retire_count); end
      repeat (3) @(negedge clk);
      checks++; if (start_cnt - base != 1 || state !== ST_IDLE) begin fails++; $display("FAIL step_single: got %0d kicks state %0d want 1 kick state 0", start_cnt - base, state); end
   endtask

   task automatic test_run4();
      int base;
      apply_reset();
      base = start_cnt;
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_state(ST_IF, 6);
         checks++; if (start_kick !== 1'b1) begin fails++; $display("FAIL run4_kick%0d: got %b want 1", i, start_kick); end
         if (i > 0) begin
            checks++; if (cyc - wb_cyc != 2) begin fails++; $display("FAIL run4_latency%0d: got %0d want 2", i, cyc - wb_cyc); end
         end
         if (i == 3) run = 1'b0;
         run_stages(0, 4, 0, -1);
      end
      checks++; if (state !== ST_IDLE) begin fails++; $display("FAIL run4_idle: got %0d want 0", state); end
      checks++; if (retire_count !== exp_retire) begin fails++; $display("FAIL run4_retire: got %0d want %0d", retire_count, exp_retire); end
      repeat (3) @(negedge clk);
      checks++; if (start_cnt - base != 4) begin fails++; $display("FAIL run4_count: got %0d want 4", start_cnt - base); end
   endtask

   task automatic test_halt();
      int base;
      apply_reset();
      base = start_cnt;
      run = 1'b1;
      wait_state(ST_IF, 6);
      run_stages(0, 4, 0, -1);
      wait_state(ST_IF, 6);
      run_stages(0, 4, 1, 2);
      checks++; if (state !== ST_HALTED || halted !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL halt_enter: got state %0d halted %b busy %b want 7/1/0", state, halted, busy); end
      checks++; if (retire_count !== 4'd2) begin fails++; $display("FAIL halt_retire: got %0d want 2", retire_count); end
      pulse_step();
      repeat (4) @(negedge clk);
      checks++; if (state !== ST_HALTED || start_cnt - base != 2) begin fails++; $display("FAIL halt_hold: got state %0d kicks %0d want 7/2", state, start_cnt - base); end
      resume = 1'b1; @(negedge clk); resume = 1'b0;
      checks++; if (state !== ST_IDLE) begin fails++; $display("FAIL halt_resume: got %0d want 0", state); end
      @(negedge clk);
      checks++; if (state !== ST_LAUNCH) begin fails++; $display("FAIL halt_relaunch: got %0d want 1", state); end
      run = 1'b0;
      wait_state(ST_IF, 4);
      run_stages(0, 4, 0, -1);
      checks++; if (state !== ST_IDLE || retire_count !== 4'd3) begin fails++; $display("FAIL halt_after: got state %0d retire %0d want 0/3", state, retire_count); end
      halt_req = 1'b1; @(negedge clk); halt_req = 1'b0;
      checks++; if (state !== ST_HALTED) begin fails++; $display("FAIL halt_idle: got %0d want 7", state); end
      resume = 1'b1; @(negedge clk); resume = 1'b0;
      pulse_step();
      wait_state(ST_IF, 4);
      run_stages(0, 4, 0, 4);
      checks++; if (state !== ST_HALTED || retire_count !== 4'd4) begin fails++; $display("FAIL halt_with_wb: got state %0d retire %0d want 7/4", state, retire_count); end
      resume = 1'b1; @(negedge clk); resume = 1'b0;
   endtask

   task automatic test_timeout();
      apply_reset();
      pulse_step();
      wait_state(ST_IF, 4);
      run_stages(0, 2, 0, -1);
      repeat (14) @(negedge clk);
      checks++; if (state !== ST_MEM) begin fails++; $display("FAIL timeout_cycle15: got %0d want 5", state); end
      @(negedge clk);
      checks++; if (state !== ST_ERROR || err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin fails++; $display("FAIL timeout_error: got state %0d err %b code %0d busy %b want 8/1/1/0", state, err, err_code, busy); end
      repeat (3) @(negedge clk);
      checks++; if (state !== ST_ERROR) begin fails++; $display("FAIL timeout_sticky: got %0d want 8", state); end
      clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
      checks++; if (state !== ST_IDLE || err !== 1'b0 || err_code !== 2'd0) begin fails++; $display("FAIL timeout_clear: got state %0d err %b code %0d want 0/0/0", state, err, err_code); end
      pulse_step();
      wait_state(ST_IF, 4);
      run_stages(0, 2, 0, -1);
      run_stages(3, 3, 14, -1);
      checks++; if (state !== ST_WB || err !== 1'b0) begin fails++; $display("FAIL timeout_edge_kick: got state %0d err %b want 6/0", state, err); end
      run_stages(4, 4, 0, -1);
      checks++; if (state !== ST_IDLE || retire_count !== exp_retire) begin fails++; $display("FAIL timeout_retire: got state %0d retire %0d want 0/%0d", state, retire_count, exp_retire); end
   endtask

   task automatic test_protocol();
      apply_reset();
      pulse_step();
      wait_state(ST_IF, 4);
      run_stages(0, 0, 0, -1);
      kick = 5'b00100; @(negedge clk); kick = 5'b0;
      checks++; if (state !== ST_ERROR || err_code !== 2'd2) begin fails++; $display("FAIL order_wrong: got state %0d code %0d want 8/2", state, err_code); end
      clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
      pulse_step();
      wait_state(ST_IF, 4);
      run_stages(0, 0, 0, -1);
      kick = 5'b00110; @(negedge clk); kick = 5'b0;
      checks++; if (state !== ST_ERROR || err_code !== 2'd2) begin fails++; $display("FAIL order_both: got state %0d code %0d want 8/2", state, err_code); end
      clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
      kick = 5'b11111; @(negedge clk); kick = 5'b0;
      checks++; if (state !== ST_IDLE || err !== 1'b0 || retire_count !== 4'd0) begin fails++; $display("FAIL order_idle_ignore: got state %0d err %b retire %0d want 0/0/0", state, err, retire_count); end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 15; i++) begin
         pulse_step();
         wait_state(ST_IF, 4);
         run_stages(0, 4, 0, -1);
      end
      checks++; if (retire_count !== 4'd15 || retire_count !== exp_retire) begin fails++; $display("FAIL wrap_15: got %0d want 15", retire_count); end
      pulse_step();
      wait_state(ST_IF, 4);
      run_stages(0, 4, 0, -1);
      checks++; if (retire_count !== 4'd0 || retire_count !== exp_retire) begin fails++; $display("FAIL wrap_0: got %0d want 0", retire_count); end
   endtask

   task automatic test_async_reset();
      pulse_step();
      wait_state(ST_IF, 4);
      run_stages(0, 1, 0, -1);
      checks++; if (state !== ST_EX) begin fails++; $display("FAIL areset_pre: got %0d want 4", state); end
      #2 reset = 1'b1;
      #1;
      checks++; if (state !== ST_IDLE || {start_kick, busy, halted, err} !== 4'b0 || err_code !== 2'd0) begin fails++; $display("FAIL areset_now: got state %0d flags %b code %0d want 0/0000/0", state, {start_kick, busy, halted, err}, err_code); end
      checks++; if (retire_count !== 4'd0) begin fails++; $display("FAIL areset_retire: got %0d want 0", retire_count); end
      @(negedge clk);
      reset = 1'b0;
      exp_retire = 4'd0;
      kick = 5'b00100; @(negedge clk); kick = 5'b01000; @(negedge clk); kick = 5'b0;
      checks++; if (state !== ST_IDLE || busy !== 1'b0) begin fails++; $display("FAIL areset_stale_kicks: got state %0d busy %b want 0/0", state, busy); end
   endtask

   initial begin
      test_reset();
      test_step();
      test_run4();
      test_halt();
      test_timeout();
      test_protocol();
      test_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
